// File: rtl/vTPU_pack.sv
// rtl/vTPU_pack.sv - shared instruction format, opcodes and issue-queue types
package vTPU_pack;

    typedef struct packed {
        logic [7:0]  op_code;
        logic [15:0] address;
        logic [15:0] calc_length;
    } INSTRUCTION_TYPE;

    localparam logic [7:0] SYNCHRONIZE_OPCODE = 8'hFF;

    typedef enum logic {
        ISSUE,
        WAIT_IDLE
    } barrier_state_t;

    function automatic logic is_synchronize(input INSTRUCTION_TYPE instr);
        return instr.op_code == SYNCHRONIZE_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_issue_queue.sv
// rtl/instruction_issue_queue.sv - FWFT instruction FIFO with synchronize barrier gating issue
module instruction_issue_queue
    import vTPU_pack::*;
#(
    parameter int DEPTH              = 8,
    parameter int ALMOST_FULL_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  INSTRUCTION_TYPE            instruction_input,
    input  logic                       instruction_write,
    output logic                       instruction_busy,
    output INSTRUCTION_TYPE            instruction_output,
    output logic                       instruction_valid,
    input  logic                       instruction_read,
    input  logic                       units_idle,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] BUSY_LEVEL = CNT_W'(DEPTH - ALMOST_FULL_MARGIN);

    INSTRUCTION_TYPE mem_q [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             overflow_q, overflow_d;
    barrier_state_t   state_q, state_d;

    INSTRUCTION_TYPE  head;
    logic             head_barrier;
    logic             full;
    logic             push;
    logic             pop;

    assign head         = mem_q[rd_ptr_q];
    assign head_barrier = is_synchronize(head);
    assign full         = (count_q == FULL_LEVEL);

    // Flush wins over any same-cycle push or pop; a pop frees the slot a full-queue push needs.
    assign pop  = enable && !flush && instruction_read && instruction_valid;
    assign push = enable && !flush && instruction_write && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= ISSUE;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    // Storage is deliberately not reset; contents only matter once counted.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= instruction_input;
        end
    end

    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        if (enable) begin
            if (flush) begin
                count_d  = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
                if (instruction_write && full && !pop) overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            if (flush) begin
                state_d = ISSUE;
            end else begin
                case (state_q)
                    ISSUE: begin
                        if ((count_q != '0) && head_barrier && !units_idle) state_d = WAIT_IDLE;
                    end
                    WAIT_IDLE: begin
                        if (units_idle || (count_q == '0) || !head_barrier) state_d = ISSUE;
                    end
                    default: state_d = ISSUE;
                endcase
            end
        end
    end

    always_comb begin
        instruction_valid  = (count_q != '0) && (!head_barrier || units_idle);
        instruction_busy   = (count_q >= BUSY_LEVEL);
        instruction_output = head;
        occupancy          = count_q;
        overflow           = overflow_q;
    end

endmodule

// File: tb/tb_instruction_issue_queue.sv
// tb/tb_instruction_issue_queue.sv - directed vector bench for instruction_issue_queue
module tb_instruction_issue_queue;
    import vTPU_pack::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    INSTRUCTION_TYPE instruction_input;
    logic            instruction_write;
    logic            instruction_busy;
    INSTRUCTION_TYPE instruction_output;
    logic            instruction_valid;
    logic            instruction_read;
    logic            units_idle;
    logic            flush;
    logic [2:0]      occupancy;
    logic            overflow;

    int total = 0;
    int bad   = 0;

    instruction_issue_queue #(.DEPTH(4), .ALMOST_FULL_MARGIN(1)) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .instruction_input  (instruction_input),
        .instruction_write  (instruction_write),
        .instruction_busy   (instruction_busy),
        .instruction_output (instruction_output),
        .instruction_valid  (instruction_valid),
        .instruction_read   (instruction_read),
        .units_idle         (units_idle),
        .flush              (flush),
        .occupancy          (occupancy),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            en;
        logic            wr;
        logic            rd;
        logic            idle;
        INSTRUCTION_TYPE d;
        int              occ;
        logic            v;
        logic            b;
        logic            o;
        logic            chk;
        INSTRUCTION_TYPE out;
    } vec_t;

    vec_t vt [15];

    function automatic INSTRUCTION_TYPE ins(input logic [7:0] op, input logic [15:0] a);
        INSTRUCTION_TYPE t;
        t.op_code     = op;
        t.address     = a;
        t.calc_length = {a[14:0], 1'b1};
        return t;
    endfunction

    function automatic vec_t mkv(input logic en, wr, rd, input INSTRUCTION_TYPE d,
                                 input int occ, input logic v, b, o, chk,
                                 input INSTRUCTION_TYPE out);
        vec_t r;
        r.en = en; r.wr = wr; r.rd = rd; r.idle = 1'b1; r.d = d;
        r.occ = occ; r.v = v; r.b = b; r.o = o; r.chk = chk; r.out = out;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Inputs are driven on the falling edge; outputs are checked 1ns later, before the next rising edge.
    task automatic step(input string nm, input logic r, en, wr, rd, idle, fl,
                        input INSTRUCTION_TYPE d, input int occ, input logic v, b, o, chk,
                        input INSTRUCTION_TYPE out);
        @(negedge clk);
        rst = r; enable = en; instruction_write = wr; instruction_read = rd;
        units_idle = idle; flush = fl; instruction_input = d;
        #1;
        check({nm, ".occ"},   64'(occupancy),         64'(occ));
        check({nm, ".valid"}, 64'(instruction_valid), 64'(v));
        check({nm, ".busy"},  64'(instruction_busy),  64'(b));
        check({nm, ".ovf"},   64'(overflow),          64'(o));
        if (chk) check({nm, ".out"}, 64'(instruction_output), 64'(out));
    endtask

    INSTRUCTION_TYPE A, B, C, D, E, F, G, N, SYNC, X, Y;
    INSTRUCTION_TYPE P [13];

    initial begin
        A = ins(8'h01, 16'h000A); B = ins(8'h02, 16'h000B); C = ins(8'h03, 16'h000C);
        D = ins(8'h04, 16'h000D); E = ins(8'h05, 16'h000E); F = ins(8'h06, 16'h000F);
        G = ins(8'h07, 16'h0010); N = ins(8'h00, 16'h0000);
        SYNC = ins(SYNCHRONIZE_OPCODE, 16'h0100); X = ins(8'h11, 16'h0200); Y = ins(8'h12, 16'h0300);
        for (int i = 0; i < 13; i++) P[i] = ins(8'h20 + 8'(i), 16'h1000 + 16'(i));

        //             en  wr  rd  data occ v  b  o  chk out
        vt[0]  = mkv(1, 0, 0, N, 0, 0, 0, 0, 0, N);
        vt[1]  = mkv(1, 1, 0, A, 0, 0, 0, 0, 0, N);
        vt[2]  = mkv(1, 1, 0, B, 1, 1, 0, 0, 1, A);
        vt[3]  = mkv(1, 1, 0, C, 2, 1, 0, 0, 1, A);
        vt[4]  = mkv(1, 1, 0, D, 3, 1, 1, 0, 1, A);
        vt[5]  = mkv(1, 1, 0, E, 4, 1, 1, 0, 1, A);
        vt[6]  = mkv(1, 0, 0, N, 4, 1, 1, 1, 1, A);
        vt[7]  = mkv(1, 1, 1, F, 4, 1, 1, 1, 1, A);
        vt[8]  = mkv(1, 0, 1, N, 4, 1, 1, 1, 1, B);
        vt[9]  = mkv(1, 0, 1, N, 3, 1, 1, 1, 1, C);
        vt[10] = mkv(1, 0, 1, N, 2, 1, 0, 1, 1, D);
        vt[11] = mkv(1, 0, 1, N, 1, 1, 0, 1, 1, F);
        vt[12] = mkv(1, 0, 1, N, 0, 0, 0, 1, 0, N);
        vt[13] = mkv(0, 1, 0, G, 0, 0, 0, 1, 0, N);
        vt[14] = mkv(1, 0, 0, N, 0, 0, 0, 1, 0, N);

        rst = 1'b1; enable = 1'b1; instruction_write = 1'b0; instruction_read = 1'b0;
        units_idle = 1'b1; flush = 1'b0; instruction_input = N;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++)
            step($sformatf("vec%0d", i), 1'b0, vt[i].en, vt[i].wr, vt[i].rd, vt[i].idle, 1'b0,
                 vt[i].d, vt[i].occ, vt[i].v, vt[i].b, vt[i].o, vt[i].chk, vt[i].out);

        // Pointer wrap: hold occupancy at 2 through ten push/pop pairs.
        step("wrap_fill0", 0, 1, 1, 0, 1, 0, P[0], 0, 0, 0, 1, 0, N);
        step("wrap_fill1", 0, 1, 1, 0, 1, 0, P[1], 1, 1, 0, 1, 1, P[0]);
        for (int k = 0; k < 10; k++)
            step($sformatf("wrap%0d", k), 0, 1, 1, 1, 1, 0, P[k+2], 2, 1, 0, 1, 1, P[k]);

        // Flush at occupancy 3 with a same-cycle push.
        step("flush_pre",  0, 1, 1, 0, 1, 0, P[12], 2, 1, 0, 1, 1, P[10]);
        step("flush_cyc",  0, 1, 1, 0, 1, 1, G,     3, 1, 1, 1, 1, P[10]);
        step("flush_post", 0, 1, 0, 0, 1, 0, N,     0, 0, 0, 1, 0, N);

        // Barrier at head holds issue until units_idle rises.
        step("bar_push0", 0, 1, 1, 0, 0, 0, SYNC, 0, 0, 0, 1, 0, N);
        step("bar_push1", 0, 1, 1, 0, 0, 0, X,    1, 0, 0, 1, 0, N);
        for (int k = 0; k < 5; k++)
            step($sformatf("bar_wait%0d", k), 0, 1, 0, 1, 0, 0, N, 2, 0, 0, 1, 0, N);
        step("bar_release", 0, 1, 0, 1, 1, 0, N, 2, 1, 0, 1, 1, SYNC);
        step("bar_next",    0, 1, 0, 1, 1, 0, N, 1, 1, 0, 1, 1, X);
        step("bar_empty",   0, 1, 0, 0, 1, 0, N, 0, 0, 0, 1, 0, N);

        // Reset while waiting on a barrier with two entries queued.
        step("rst_push0", 0, 1, 1, 0, 0, 0, SYNC, 0, 0, 0, 1, 0, N);
        step("rst_push1", 0, 1, 1, 0, 0, 0, X,    1, 0, 0, 1, 0, N);
        step("rst_wait",  0, 1, 0, 0, 0, 0, N,    2, 0, 0, 1, 0, N);
        step("rst_cyc",   1, 1, 1, 1, 0, 1, Y,    2, 0, 0, 1, 0, N);
        step("rst_post",  0, 1, 1, 0, 1, 0, Y,    0, 0, 0, 0, 0, N);
        step("rst_issue", 0, 1, 0, 0, 1, 0, N,    1, 1, 0, 0, 1, Y);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
